prio_arb_n: RTL and testbench
=============================

PRIO_ARB_N -- requirements
Module: prio_arb_n

Interface
REQ-001 The block SHALL have parameter N, default 8, giving the number of request channels (2..32).
REQ-002 The block SHALL have parameter IW, default $clog2(N), giving the grant index width.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock, all state on rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port en, input, 1 bit: arbiter enable; low forces idle.
REQ-006 The block SHALL have port req, input, N bits: request vector, bit k = channel k.
REQ-007 The block SHALL have port ack, input, 1 bit: consumer accepts current grant.
REQ-008 The block SHALL have port gnt_valid, output, 1 bit: a grant is held.
REQ-009 The block SHALL have port gnt_idx, output, IW bits: binary index of granted channel.
REQ-010 The block SHALL have port gnt_oh, output, N bits: one-hot grant, zero when gnt_valid low.

Function
REQ-011 The block SHALL implement a two-state FSM: IDLE, GRANT.
REQ-012 In IDLE with en=1 and req!=0, the winner SHALL be selected combinationally and registered, giving GRANT, gnt_valid=1, gnt_idx and gnt_oh at the next edge (1-cycle latency).
REQ-013 Without round-robin, the winner SHALL be the highest set index of req (bit N-1 highest priority).
REQ-014 In IDLE with req==0 or en=0, the block SHALL stay in IDLE with all outputs zero.
REQ-015 In GRANT, gnt_idx/gnt_oh SHALL remain stable regardless of other req changes until release.
REQ-016 Release SHALL occur on ack=1, or on req[gnt_idx]=0, or on en=0; the next state SHALL be IDLE with outputs zero at that edge.
REQ-017 Simultaneous ack and req drop SHALL be treated as a single release.
REQ-018 After release, at least one IDLE cycle SHALL occur before the next grant (no back-to-back grant).
REQ-019 gnt_oh SHALL equal (1 << gnt_idx) whenever gnt_valid=1.

Reset
REQ-020 While rst=1, the block SHALL hold state IDLE, gnt_valid=0, gnt_idx=0, gnt_oh=0, last-grant pointer=N-1, independent of clk.
REQ-021 rst asserted mid-GRANT SHALL drop the grant immediately (asynchronously).
REQ-022 The first arbitration after rst deassertion SHALL occur on the first rising edge with rst=0.

Configuration
REQ-023 Macro PRIO_ARB_RR_EN, when defined, SHALL compile in round-robin mode: a pointer register holds the last granted index, updated on each grant.
REQ-024 With PRIO_ARB_RR_EN, the search SHALL start at (pointer+1) mod N, ascending with wrap, first set bit wins; from reset the order starts at channel 0.
REQ-025 Without PRIO_ARB_RR_EN, the pointer SHALL not exist and fixed priority per REQ-013 SHALL apply.

Structure
REQ-026 A shared package prio_arb_pkg SHALL hold the FSM state encoding constants (IDLE=0, GRANT=1).
REQ-027 A combinational sub-module prio_enc_n (parameters N, IW; inputs vector and start offset; outputs index and found) SHALL perform the winner search and be instantiated once.

Verification
REQ-028 N=8, fixed: req=8'b0000_1100 in IDLE -> next edge gnt_valid=1, gnt_idx=3, gnt_oh=8'b0000_1000.
REQ-029 N=8, fixed: hold req=8'b1000_0001, pulse ack -> grants alternate 7, idle, 7, with one idle cycle between each.
REQ-030 N=8, RR: req=8'hFF held, ack every grant -> gnt_idx sequence 0,1,2,...,7,0 with idle cycles between.
REQ-031 N=8: grant on idx 5, then req[5] drops while req[2]=1 -> next edge idle, following edge gnt_idx=2.
REQ-032 N=8: rst asserted mid-GRANT between edges -> gnt_valid=0 and gnt_oh=0 immediately; after release, RR order restarts at 0.
REQ-033 N=8: en=0 with req=8'hFF -> outputs remain 0; en=1 -> next edge grant (idx 7 fixed, idx 0 RR).

Source files
------------

// File: rtl/prio_arb_pkg.sv
// ----------------------------------------------------------------------------
// prio_arb_pkg
// Shared constants for the prio_arb_n request arbiter.
//   ST_IDLE  : no grant held, arbitration allowed on the next edge
//   ST_GRANT : one channel holds the grant until released
// No ports (package).
// ----------------------------------------------------------------------------
package prio_arb_pkg;

    // Two-state arbiter FSM encoding. The single state bit is what
    // gnt_valid reflects, so the state is directly observable on that port.
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

endpackage

// File: rtl/prio_enc_n.sv
// ----------------------------------------------------------------------------
// prio_enc_n
// Combinational circular first-set-bit search. Starting at position
// 'start', positions are scanned in ascending order with wrap-around at N;
// the first set bit of 'vec' wins.
// Parameters:
//   N  : vector width (2..32)
//   IW : index width, $clog2(N)
// Ports:
//   vec   (in,  N)  : candidate bit vector
//   start (in,  IW) : first position examined, must be < N
//   idx   (out, IW) : position of the winning bit (0 when none found)
//   found (out, 1)  : at least one bit of vec is set
// ----------------------------------------------------------------------------
module prio_enc_n #(
    parameter int N  = 8,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  vec,
    input  logic [IW-1:0] start,
    output logic [IW-1:0] idx,
    output logic          found
);

    // One extra bit so start + i cannot overflow before the wrap subtraction.
    logic [IW:0] pos;

    always_comb begin
        idx   = '0;
        found = 1'b0;
        pos   = '0;
        for (int i = 0; i < N; i++) begin
            pos = {1'b0, start} + (IW+1)'(i);
            if (pos >= (IW+1)'(N)) begin
                pos = pos - (IW+1)'(N);
            end
            if (!found && vec[pos[IW-1:0]]) begin
                found = 1'b1;
                idx   = pos[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/prio_arb_n.sv
// ----------------------------------------------------------------------------
// prio_arb_n
// N-channel request arbiter with a hold-until-release grant.
// From IDLE, when enabled and any request is set, the winner is registered
// at the next rising edge (1-cycle latency). The grant is then held stable
// until ack, loss of the granted request, or en low; the release edge
// returns to IDLE, so at least one idle cycle separates two grants.
//
// Priority:
//   default           : fixed, highest set index wins (bit N-1 highest)
//   PRIO_ARB_RR_EN    : round-robin; search starts one past the last granted
//                       index, ascending with wrap. The last-grant pointer
//                       resets to N-1 so the first search starts at channel 0.
//
// Parameters:
//   N  : number of request channels (2..32)
//   IW : grant index width, $clog2(N)
// Ports:
//   clk       (in,  1)  : clock, all state on rising edge
//   rst       (in,  1)  : asynchronous active-high reset
//   en        (in,  1)  : arbiter enable; low forces/keeps IDLE
//   req       (in,  N)  : request vector, bit k = channel k
//   ack       (in,  1)  : consumer accepts the current grant (releases it)
//   gnt_valid (out, 1)  : a grant is held (FSM is in GRANT)
//   gnt_idx   (out, IW) : binary index of granted channel, 0 when idle
//   gnt_oh    (out, N)  : one-hot grant, 0 when idle
// ----------------------------------------------------------------------------
module prio_arb_n
    import prio_arb_pkg::*;
#(
    parameter int N  = 8,
    parameter int IW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [N-1:0]  req,
    input  logic          ack,
    output logic          gnt_valid,
    output logic [IW-1:0] gnt_idx,
    output logic [N-1:0]  gnt_oh
);

    logic [0:0]    state;
    logic [N-1:0]  enc_vec;
    logic [IW-1:0] enc_start;
    logic [IW-1:0] enc_idx;
    logic          enc_found;
    logic [IW-1:0] win_idx;
    logic [N-1:0]  win_oh;
    logic          grant_now;
    logic          release_now;

`ifdef PRIO_ARB_RR_EN
    // Last granted index; the search begins just past it.
    logic [IW-1:0] ptr;

    always_comb begin
        enc_vec   = req;
        enc_start = (ptr == IW'(N-1)) ? '0 : ptr + IW'(1);
        win_idx   = enc_idx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= IW'(N-1);
        end else if (grant_now) begin
            ptr <= win_idx;
        end
    end
`else
    // Fixed priority reuses the ascending search: the request vector is
    // bit-reversed so the first hit is the highest original index, and the
    // index is mirrored back.
    always_comb begin
        enc_vec = '0;
        for (int k = 0; k < N; k++) begin
            enc_vec[k] = req[N-1-k];
        end
        enc_start = '0;
        win_idx   = IW'(N-1) - enc_idx;
    end
`endif

    prio_enc_n #(
        .N  (N),
        .IW (IW)
    ) u_enc (
        .vec   (enc_vec),
        .start (enc_start),
        .idx   (enc_idx),
        .found (enc_found)
    );

    always_comb begin
        win_oh = N'(1) << win_idx;
    end

    // Arbitration only from IDLE; release checks only the held channel.
    assign grant_now   = (state == ST_IDLE) && en && enc_found;
    assign release_now = !en || ack || !req[gnt_idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            gnt_idx <= '0;
            gnt_oh  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant_now) begin
                        state   <= ST_GRANT;
                        gnt_idx <= win_idx;
                        gnt_oh  <= win_oh;
                    end
                end
                ST_GRANT: begin
                    // Any combination of release causes is one release.
                    if (release_now) begin
                        state   <= ST_IDLE;
                        gnt_idx <= '0;
                        gnt_oh  <= '0;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    gnt_idx <= '0;
                    gnt_oh  <= '0;
                end
            endcase
        end
    end

    assign gnt_valid = (state == ST_GRANT);

endmodule

// File: tb/tb_prio_arb_n.sv
// ----------------------------------------------------------------------------
// tb_prio_arb_n
// Self-checking bench for prio_arb_n with N=8. Expected grant indices are
// hand-computed for both the fixed-priority build and the PRIO_ARB_RR_EN
// build; the column matching the current build is used.
// ----------------------------------------------------------------------------
module tb_prio_arb_n;

    localparam int N  = 8;
    localparam int IW = 3;
    localparam int W  = 1 + IW + N;

`ifdef PRIO_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic          clk;
    logic          rst;
    logic          en;
    logic [N-1:0]  req;
    logic          ack;
    logic          gnt_valid;
    logic [IW-1:0] gnt_idx;
    logic [N-1:0]  gnt_oh;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    prio_arb_n #(
        .N  (N),
        .IW (IW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .req       (req),
        .ack       (ack),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx),
        .gnt_oh    (gnt_oh)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];

    typedef struct {
        logic       en;
        logic [7:0] req;
        logic       ack;
        logic       valid;
        int         idx_fixed;
        int         idx_rr;
        string      name;
    } vec_t;

    task automatic cmp(input string name, input string field,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s got %0h expected %0h", name, field, act, exp);
        end
    endtask

    // Push the expected outputs for a step.
    task automatic expect_out(input logic valid, input int idx_fixed, input int idx_rr);
        logic [IW-1:0] e_idx;
        logic [N-1:0]  e_oh;
        e_idx = valid ? IW'(RR ? idx_rr : idx_fixed) : '0;
        e_oh  = '0;
        if (valid) e_oh[e_idx] = 1'b1;
        exp_q.push_back({valid, e_idx, e_oh});
    endtask

    // Pop one expectation and compare it with the current outputs.
    task automatic check_out(input string name);
        logic [W-1:0]  e;
        if (exp_q.size() == 0) begin
            cmp(name, "queue_empty", 32'd1, 32'd0);
            return;
        end
        e = exp_q.pop_front();
        cmp(name, "gnt_valid", 32'(gnt_valid), 32'(e[W-1]));
        cmp(name, "gnt_idx",   32'(gnt_idx),   32'(e[N+IW-1:N]));
        cmp(name, "gnt_oh",    32'(gnt_oh),    32'(e[N-1:0]));
    endtask

    // ---------------- driver tasks ----------------
    // Drive inputs at the falling edge, check #1 after the following rising edge.
    task automatic step(input logic e, input logic [7:0] r, input logic a,
                        input logic valid, input int idx_fixed, input int idx_rr,
                        input string name);
        @(negedge clk);
        en  = e;
        req = r;
        ack = a;
        expect_out(valid, idx_fixed, idx_rr);
        @(posedge clk);
        #1;
        check_out(name);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        en  = 1'b0;
        req = '0;
        ack = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // ---------------- vector table ----------------
    vec_t tbl[14];

    initial begin
        tbl[0]  = '{1'b1, 8'h00, 1'b0, 1'b0, 0, 0, "idle_no_req"};
        tbl[1]  = '{1'b1, 8'h0C, 1'b0, 1'b1, 3, 2, "grant_0c"};
        tbl[2]  = '{1'b1, 8'h8C, 1'b0, 1'b1, 3, 2, "hold_stable"};
        tbl[3]  = '{1'b1, 8'h8C, 1'b1, 1'b0, 0, 0, "ack_release"};
        tbl[4]  = '{1'b1, 8'h8C, 1'b0, 1'b1, 7, 3, "grant_8c"};
        tbl[5]  = '{1'b1, 8'h00, 1'b0, 1'b0, 0, 0, "req_drop_release"};
        tbl[6]  = '{1'b0, 8'hFF, 1'b0, 1'b0, 0, 0, "en_low_a"};
        tbl[7]  = '{1'b0, 8'hFF, 1'b0, 1'b0, 0, 0, "en_low_b"};
        tbl[8]  = '{1'b1, 8'hFF, 1'b0, 1'b1, 7, 4, "en_high_grant"};
        tbl[9]  = '{1'b0, 8'hFF, 1'b0, 1'b0, 0, 0, "en_low_release"};
        tbl[10] = '{1'b1, 8'h01, 1'b0, 1'b1, 0, 0, "grant_ch0"};
        tbl[11] = '{1'b1, 8'h00, 1'b1, 1'b0, 0, 0, "ack_and_drop"};
        tbl[12] = '{1'b1, 8'h01, 1'b0, 1'b1, 0, 0, "regrant_ch0"};
        tbl[13] = '{1'b1, 8'h00, 1'b0, 1'b0, 0, 0, "final_drop"};
    end

    // ---------------- test sequence ----------------
    initial begin
        rst = 1'b1;
        en  = 1'b0;
        req = '0;
        ack = 1'b0;

        // Reset state, sampled between edges while rst is high.
        #12;
        expect_out(1'b0, 0, 0);
        check_out("reset_state");
        @(negedge clk);
        rst = 1'b0;

        // Table-driven vectors.
        for (int i = 0; i < 14; i++) begin
            step(tbl[i].en, tbl[i].req, tbl[i].ack,
                 tbl[i].valid, tbl[i].idx_fixed, tbl[i].idx_rr, tbl[i].name);
        end

        // Two requesters held, ack pulsed on each grant.
        do_reset();
        step(1'b1, 8'h81, 1'b0, 1'b1, 7, 0, "alt_g1");
        step(1'b1, 8'h81, 1'b1, 1'b0, 0, 0, "alt_i1");
        step(1'b1, 8'h81, 1'b0, 1'b1, 7, 7, "alt_g2");
        step(1'b1, 8'h81, 1'b1, 1'b0, 0, 0, "alt_i2");
        step(1'b1, 8'h81, 1'b0, 1'b1, 7, 0, "alt_g3");

        // All requesting, ack every grant: rotation through all channels.
        do_reset();
        for (int k = 0; k <= N; k++) begin
            step(1'b1, 8'hFF, 1'b0, 1'b1, 7, k % N, $sformatf("sweep_g%0d", k));
            step(1'b1, 8'hFF, 1'b1, 1'b0, 0, 0,     $sformatf("sweep_i%0d", k));
        end

        // Granted request drops while another is pending.
        do_reset();
        step(1'b1, 8'h20, 1'b0, 1'b1, 5, 5, "drop_g5");
        step(1'b1, 8'h24, 1'b0, 1'b1, 5, 5, "drop_hold5");
        step(1'b1, 8'h04, 1'b0, 1'b0, 0, 0, "drop_idle");
        step(1'b1, 8'h04, 1'b0, 1'b1, 2, 2, "drop_g2");

        // Asynchronous reset in the middle of a grant.
        do_reset();
        step(1'b1, 8'hFF, 1'b0, 1'b1, 7, 0, "arst_g_a");
        step(1'b1, 8'hFF, 1'b1, 1'b0, 0, 0, "arst_i");
        step(1'b1, 8'hFF, 1'b0, 1'b1, 7, 1, "arst_g_b");
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        expect_out(1'b0, 0, 0);
        check_out("arst_immediate");
        @(negedge clk);
        expect_out(1'b0, 0, 0);
        check_out("arst_held");
        rst = 1'b0;
        step(1'b1, 8'hFF, 1'b0, 1'b1, 7, 0, "arst_restart");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global time bound so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout got running expected finished");
        $fatal(1);
    end

endmodule
